// File: rtl/morra_match_stats.sv
// Per-game statistics records and best-of match verdict for the MorraCinese game FSM.
// Optional streak outputs (REC_S1/REC_S2) are built when MORRA_STATS_STREAK_EN is defined.
module morra_match_stats #(
   parameter int CNT_W      = 4,
   parameter int MATCH_WINS = 2,
   parameter int MAX_GAMES  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             START,
   input  logic [1:0]       ROUND,
   input  logic [1:0]       GAME,
   input  logic             CLR,
   input  logic             REC_READY,
   output logic             REC_VALID,
   output logic [1:0]       REC_WINNER,
   output logic [CNT_W-1:0] REC_R1,
   output logic [CNT_W-1:0] REC_R2,
   output logic [CNT_W-1:0] REC_RD,
   output logic [2:0]       REC_IDX,
   output logic [2:0]       WINS1,
   output logic [2:0]       WINS2,
   output logic             MATCH_DONE,
   output logic [1:0]       MATCH_WINNER,
`ifdef MORRA_STATS_STREAK_EN
   output logic [CNT_W-1:0] REC_S1,
   output logic [CNT_W-1:0] REC_S2,
`endif
   output logic             OVF
);

   localparam logic [1:0]       S_IDLE   = 2'd0;
   localparam logic [1:0]       S_PLAY   = 2'd1;
   localparam logic [1:0]       S_DONE   = 2'd2;
   localparam logic [2:0]       WIN_LIM  = 3'(MATCH_WINS);
   localparam logic [2:0]       GAME_LIM = 3'(MAX_GAMES);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   logic [1:0]       state_q, state_d, prev_game_q, mwin_q, mwin_d, rwin_q, rwin_d;
   logic [CNT_W-1:0] r1_q, r1_d, r2_q, r2_d, rd_q, rd_d;
   logic [CNT_W-1:0] rr1_q, rr1_d, rr2_q, rr2_d, rrd_q, rrd_d;
   logic [2:0]       games_q, games_d, wins1_q, wins1_d, wins2_q, wins2_d, ridx_q, ridx_d;
   logic             done_q, done_d, ovf_q, ovf_d, vld_q, vld_d;
   logic             play_s, game_end_s;
   logic [CNT_W-1:0] r1_s, r2_s, rd_s;
   logic [2:0]       w1_s, w2_s, games_s;
`ifdef MORRA_STATS_STREAK_EN
   logic [CNT_W-1:0] c1_q, c1_d, c2_q, c2_d, m1_q, m1_d, m2_q, m2_d, rs1_q, rs1_d, rs2_q, rs2_d;
   logic [CNT_W-1:0] c1_s, c2_s, m1_s, m2_s;
`endif

   // Next-state: round counting, game-end edge detection, record build/handshake, match verdict.
   always_comb begin
      state_d = state_q;  mwin_d  = mwin_q;  rwin_d  = rwin_q;
      r1_d    = r1_q;     r2_d    = r2_q;    rd_d    = rd_q;
      rr1_d   = rr1_q;    rr2_d   = rr2_q;   rrd_d   = rrd_q;
      games_d = games_q;  wins1_d = wins1_q; wins2_d = wins2_q; ridx_d = ridx_q;
      done_d  = done_q;   ovf_d   = ovf_q;   vld_d   = vld_q;
      play_s     = (state_q == S_PLAY) && !START;
      game_end_s = play_s && (GAME != 2'b00) && (prev_game_q == 2'b00);
      r1_s = r1_q; r2_s = r2_q; rd_s = rd_q;
`ifdef MORRA_STATS_STREAK_EN
      c1_d = c1_q; c2_d = c2_q; m1_d = m1_q; m2_d = m2_q; rs1_d = rs1_q; rs2_d = rs2_q;
      c1_s = c1_q; c2_s = c2_q;
`endif
      if (play_s) begin
         case (ROUND)
            2'b01: begin
               r1_s = sat_inc(r1_q);
`ifdef MORRA_STATS_STREAK_EN
               c1_s = sat_inc(c1_q); c2_s = CNT_ZERO;
`endif
            end
            2'b10: begin
               r2_s = sat_inc(r2_q);
`ifdef MORRA_STATS_STREAK_EN
               c2_s = sat_inc(c2_q); c1_s = CNT_ZERO;
`endif
            end
            2'b11: begin
               rd_s = sat_inc(rd_q);
`ifdef MORRA_STATS_STREAK_EN
               c1_s = CNT_ZERO; c2_s = CNT_ZERO;
`endif
            end
            default: begin
               r1_s = r1_q;
            end
         endcase
      end else begin
         r1_s = r1_q;
      end
`ifdef MORRA_STATS_STREAK_EN
      m1_s = (c1_s > m1_q) ? c1_s : m1_q;
      m2_s = (c2_s > m2_q) ? c2_s : m2_q;
`endif
      w1_s    = wins1_q + ((GAME == 2'b01) ? 3'd1 : 3'd0);
      w2_s    = wins2_q + ((GAME == 2'b10) ? 3'd1 : 3'd0);
      games_s = games_q + 3'd1;

      // A transfer frees the slot; a game end in the same cycle refills it.
      if (vld_q && REC_READY) begin
         vld_d = 1'b0;
      end else begin
         vld_d = vld_q;
      end

      if (START) begin
         r1_d = CNT_ZERO; r2_d = CNT_ZERO; rd_d = CNT_ZERO;
`ifdef MORRA_STATS_STREAK_EN
         c1_d = CNT_ZERO; c2_d = CNT_ZERO; m1_d = CNT_ZERO; m2_d = CNT_ZERO;
`endif
         if (state_q == S_IDLE) begin
            state_d = S_PLAY;
         end else begin
            state_d = state_q;
         end
      end else if (game_end_s) begin
         r1_d = CNT_ZERO; r2_d = CNT_ZERO; rd_d = CNT_ZERO;
`ifdef MORRA_STATS_STREAK_EN
         c1_d = CNT_ZERO; c2_d = CNT_ZERO; m1_d = CNT_ZERO; m2_d = CNT_ZERO;
`endif
         games_d = games_s; wins1_d = w1_s; wins2_d = w2_s;
         if (vld_q && !REC_READY) begin
            ovf_d = 1'b1;
         end else begin
            vld_d = 1'b1; rwin_d = GAME; ridx_d = games_s;
            rr1_d = r1_s; rr2_d = r2_s; rrd_d = rd_s;
`ifdef MORRA_STATS_STREAK_EN
            rs1_d = m1_s; rs2_d = m2_s;
`endif
         end
         if ((w1_s >= WIN_LIM) || (w2_s >= WIN_LIM) || (games_s >= GAME_LIM)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            mwin_d  = (w1_s > w2_s) ? 2'b01 : ((w2_s > w1_s) ? 2'b10 : 2'b11);
         end else begin
            state_d = state_q;
         end
      end else begin
         r1_d = r1_s; r2_d = r2_s; rd_d = rd_s;
`ifdef MORRA_STATS_STREAK_EN
         c1_d = c1_s; c2_d = c2_s; m1_d = m1_s; m2_d = m2_s;
`endif
      end

      if (CLR) begin
         state_d = S_IDLE; games_d = 3'd0; wins1_d = 3'd0; wins2_d = 3'd0;
         done_d = 1'b0; mwin_d = 2'b00; ovf_d = 1'b0; vld_d = 1'b0;
         r1_d = CNT_ZERO; r2_d = CNT_ZERO; rd_d = CNT_ZERO;
`ifdef MORRA_STATS_STREAK_EN
         c1_d = CNT_ZERO; c2_d = CNT_ZERO; m1_d = CNT_ZERO; m2_d = CNT_ZERO;
`endif
      end else begin
         ovf_d = ovf_d;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;  prev_game_q <= 2'b00; mwin_q <= 2'b00; rwin_q <= 2'b00;
         r1_q <= CNT_ZERO;   r2_q <= CNT_ZERO;     rd_q <= CNT_ZERO;
         rr1_q <= CNT_ZERO;  rr2_q <= CNT_ZERO;    rrd_q <= CNT_ZERO;
         games_q <= 3'd0;    wins1_q <= 3'd0;      wins2_q <= 3'd0;  ridx_q <= 3'd0;
         done_q <= 1'b0;     ovf_q <= 1'b0;        vld_q <= 1'b0;
`ifdef MORRA_STATS_STREAK_EN
         c1_q <= CNT_ZERO; c2_q <= CNT_ZERO; m1_q <= CNT_ZERO; m2_q <= CNT_ZERO;
         rs1_q <= CNT_ZERO; rs2_q <= CNT_ZERO;
`endif
      end else begin
         state_q <= state_d; prev_game_q <= GAME;  mwin_q <= mwin_d; rwin_q <= rwin_d;
         r1_q <= r1_d;       r2_q <= r2_d;         rd_q <= rd_d;
         rr1_q <= rr1_d;     rr2_q <= rr2_d;       rrd_q <= rrd_d;
         games_q <= games_d; wins1_q <= wins1_d;   wins2_q <= wins2_d; ridx_q <= ridx_d;
         done_q <= done_d;   ovf_q <= ovf_d;       vld_q <= vld_d;
`ifdef MORRA_STATS_STREAK_EN
         c1_q <= c1_d; c2_q <= c2_d; m1_q <= m1_d; m2_q <= m2_d;
         rs1_q <= rs1_d; rs2_q <= rs2_d;
`endif
      end
   end

   assign REC_VALID    = vld_q;
   assign REC_WINNER   = rwin_q;
   assign REC_R1       = rr1_q;
   assign REC_R2       = rr2_q;
   assign REC_RD       = rrd_q;
   assign REC_IDX      = ridx_q;
   assign WINS1        = wins1_q;
   assign WINS2        = wins2_q;
   assign MATCH_DONE   = done_q;
   assign MATCH_WINNER = mwin_q;
   assign OVF          = ovf_q;
`ifdef MORRA_STATS_STREAK_EN
   assign REC_S1       = rs1_q;
   assign REC_S2       = rs2_q;
`endif

endmodule
